// File: rtl/logic_seq_ctrl_pkg.sv
// Shared types and default constants for the job sequencer.
// Imported by the watchdog, the controller and anything that decodes its state.
package logic_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_COMPUTE = 3'd2,
      ST_READ    = 3'd3,
      ST_FIN     = 3'd4,
      ST_ERR     = 3'd5
   } seq_state_e;

   localparam int unsigned DEF_NUM_READ = 32'd16;
   localparam int unsigned DEF_TIMEOUT  = 32'd255;

   function automatic logic is_busy(input seq_state_e s);
      return (s == ST_LOAD) || (s == ST_COMPUTE) || (s == ST_READ) || (s == ST_FIN);
   endfunction

endpackage

// File: rtl/logic_seq_ctrl_if.sv
// Host / X-buffer / ALU / SRAM signal bundle of the job sequencer.
// The sequencer uses the slave view; the host or bench drives through the master view.
interface logic_seq_ctrl_if;

   logic       start;
   logic       x_in_valid;
   logic [7:0] x_in;
   logic       xload_done;
   logic       ALU_done;
   logic       ry;
   logic [8:0] read_data;

   logic       input_load_en;
   logic       valid_input;
   logic [7:0] X_load;
   logic       ALU_en;
   logic       cs_n;
   logic [7:0] rd_addr;
   logic [8:0] result_data;
   logic       result_valid;
   logic       busy;
   logic       done;
   logic       error;

   modport master (
      output start, x_in_valid, x_in, xload_done, ALU_done, ry, read_data,
      input  input_load_en, valid_input, X_load, ALU_en, cs_n, rd_addr,
             result_data, result_valid, busy, done, error
   );

   modport slave (
      input  start, x_in_valid, x_in, xload_done, ALU_done, ry, read_data,
      output input_load_en, valid_input, X_load, ALU_en, cs_n, rd_addr,
             result_data, result_valid, busy, done, error
   );

endinterface

// File: rtl/logic_seq_ctrl_wdog.sv
// seq_wdog: per-phase cycle counter; expired marks the TIMEOUT-th cycle spent
// in the current phase (or since the last read capture).
module seq_wdog
   import logic_seq_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned W    = $clog2(TIMEOUT + 32'd1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 32'd1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear wins, then count up, saturating at the expiry value
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/logic_seq_ctrl.sv
// Job sequencer: load X samples, run the ALU, read NUM_READ result words back
// from SRAM, with a per-phase watchdog that parks the block in a sticky error state.
module logic_seq_ctrl
   import logic_seq_ctrl_pkg::*;
#(
   parameter int unsigned NUM_READ = DEF_NUM_READ,
   parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
   input  logic            clk,
   input  logic            rst,
   logic_seq_ctrl_if.slave bus
);

   localparam logic [7:0] LAST_ADDR = 8'(NUM_READ - 32'd1);

   seq_state_e state_q, state_d;
   logic [7:0] rd_addr_q, rd_addr_d;
   logic [8:0] result_data_q, result_data_d;
   logic       result_valid_q, result_valid_d;
   logic       input_load_en_q, input_load_en_d;
   logic       valid_input_q, valid_input_d;
   logic [7:0] x_load_q, x_load_d;
   logic       alu_en_q, alu_en_d;
   logic       cs_n_q, cs_n_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       error_q, error_d;

   logic       capture_s;
   logic       wdog_clear_s;
   logic       wdog_en_s;
   logic       wdog_expired_s;

   seq_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wdog_clear_s),
      .enable  (wdog_en_s),
      .expired (wdog_expired_s)
   );

   // Next state, read pointer and capture; completion events are tested before expiry
   always_comb begin
      state_d       = state_q;
      rd_addr_d     = rd_addr_q;
      result_data_d = result_data_q;
      capture_s     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            rd_addr_d = 8'd0;
            if (bus.start) state_d = ST_LOAD;
            else           state_d = ST_IDLE;
         end
         ST_LOAD: begin
            if (bus.xload_done)      state_d = ST_COMPUTE;
            else if (wdog_expired_s) state_d = ST_ERR;
            else                     state_d = ST_LOAD;
         end
         ST_COMPUTE: begin
            if (bus.ALU_done)        state_d = ST_READ;
            else if (wdog_expired_s) state_d = ST_ERR;
            else                     state_d = ST_COMPUTE;
         end
         ST_READ: begin
            if (bus.ry) begin
               capture_s     = 1'b1;
               result_data_d = bus.read_data;
               if (rd_addr_q == LAST_ADDR) begin
                  rd_addr_d = 8'd0;
                  state_d   = ST_FIN;
               end else begin
                  rd_addr_d = rd_addr_q + 8'd1;
                  state_d   = ST_READ;
               end
            end else if (wdog_expired_s) begin
               state_d = ST_ERR;
            end else begin
               state_d = ST_READ;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         ST_ERR: begin
            if (bus.start) begin
               state_d   = ST_LOAD;
               rd_addr_d = 8'd0;
            end else begin
               state_d = ST_ERR;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            rd_addr_d = 8'd0;
         end
      endcase

      // Outputs are decoded from the next state so they line up with the registered state
      input_load_en_d = (state_d == ST_LOAD);
      valid_input_d   = (state_d == ST_LOAD) && bus.x_in_valid;
      x_load_d        = bus.x_in;
      alu_en_d        = (state_d == ST_COMPUTE);
      cs_n_d          = (state_d != ST_READ);
      busy_d          = is_busy(state_d);
      done_d          = (state_d == ST_FIN);
      error_d         = (state_d == ST_ERR);
      result_valid_d  = capture_s;
   end

   assign wdog_en_s    = (state_q == ST_LOAD) || (state_q == ST_COMPUTE) || (state_q == ST_READ);
   assign wdog_clear_s = (state_d != state_q) || capture_s || (state_q == ST_IDLE);

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         rd_addr_q       <= 8'd0;
         result_data_q   <= 9'd0;
         result_valid_q  <= 1'b0;
         input_load_en_q <= 1'b0;
         valid_input_q   <= 1'b0;
         x_load_q        <= 8'd0;
         alu_en_q        <= 1'b0;
         cs_n_q          <= 1'b1;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         error_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         rd_addr_q       <= rd_addr_d;
         result_data_q   <= result_data_d;
         result_valid_q  <= result_valid_d;
         input_load_en_q <= input_load_en_d;
         valid_input_q   <= valid_input_d;
         x_load_q        <= x_load_d;
         alu_en_q        <= alu_en_d;
         cs_n_q          <= cs_n_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         error_q         <= error_d;
      end
   end

   assign bus.input_load_en = input_load_en_q;
   assign bus.valid_input   = valid_input_q;
   assign bus.X_load        = x_load_q;
   assign bus.ALU_en        = alu_en_q;
   assign bus.cs_n          = cs_n_q;
   assign bus.rd_addr       = rd_addr_q;
   assign bus.result_data   = result_data_q;
   assign bus.result_valid  = result_valid_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.error         = error_q;

endmodule

// File: tb/tb_logic_seq_ctrl.sv
// Bench for logic_seq_ctrl: a default build and a NUM_READ=1 / short-timeout build
// share one stimulus stream and are compared every cycle against a job-phase model.
module tb_logic_seq_ctrl;

   localparam int NR_A = 16;
   localparam int TO_A = 255;
   localparam int NR_B = 1;
   localparam int TO_B = 6;

   typedef enum int {P_IDLE, P_LOAD, P_COMPUTE, P_READ, P_FIN, P_ERR} phase_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic st = 1'b0, xv = 1'b0, xd = 1'b0, ad = 1'b0, ry = 1'b0;
   logic [7:0] xi = 8'd0;
   logic [8:0] rd = 9'd0;

   int n_vec = 0;
   int n_miscmp = 0;
   int cyc = 0;
   int rv_cnt_a = 0;
   int done_cnt_a = 0;

   // model state, index 0 = default build, 1 = NUM_READ=1 build
   phase_t     ph[2];
   int         mark[2];
   int         ra[2];
   logic [8:0] rdat[2];
   logic       rv[2];
   logic       vi[2];
   logic [7:0] xl[2];

   always #5 clk = ~clk;

   logic_seq_ctrl_if bus_a();
   logic_seq_ctrl_if bus_b();

   assign bus_a.start = st;  assign bus_a.x_in_valid = xv; assign bus_a.x_in = xi;
   assign bus_a.xload_done = xd; assign bus_a.ALU_done = ad; assign bus_a.ry = ry;
   assign bus_a.read_data = rd;
   assign bus_b.start = st;  assign bus_b.x_in_valid = xv; assign bus_b.x_in = xi;
   assign bus_b.xload_done = xd; assign bus_b.ALU_done = ad; assign bus_b.ry = ry;
   assign bus_b.read_data = rd;

   logic_seq_ctrl #(.NUM_READ(NR_A), .TIMEOUT(TO_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   logic_seq_ctrl #(.NUM_READ(NR_B), .TIMEOUT(TO_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Job-phase model: timeouts measured as cycles elapsed since the phase (or word) began
   task automatic model_step(input int i, input int nr, input int to);
      phase_t nx;
      logic   cap;
      logic   tmo;
      if (rst) begin
         ph[i] = P_IDLE; ra[i] = 0; rdat[i] = 9'd0; rv[i] = 1'b0;
         vi[i] = 1'b0; xl[i] = 8'd0; mark[i] = cyc + 1;
         return;
      end
      nx  = ph[i];
      cap = 1'b0;
      tmo = ((cyc - mark[i] + 1) == to);
      case (ph[i])
         P_IDLE:    begin ra[i] = 0; if (st) nx = P_LOAD; end
         P_LOAD:    if (xd) nx = P_COMPUTE; else if (tmo) nx = P_ERR;
         P_COMPUTE: if (ad) nx = P_READ;    else if (tmo) nx = P_ERR;
         P_READ: begin
            if (ry) begin
               cap = 1'b1;
               rdat[i] = rd;
               if (ra[i] == nr - 1) begin ra[i] = 0; nx = P_FIN; end
               else ra[i] = ra[i] + 1;
            end else if (tmo) nx = P_ERR;
         end
         P_FIN:     nx = P_IDLE;
         P_ERR:     if (st) begin nx = P_LOAD; ra[i] = 0; end
         default:   nx = P_IDLE;
      endcase
      if (nx != ph[i] || cap) mark[i] = cyc + 1;
      rv[i] = cap;
      vi[i] = (nx == P_LOAD) && xv;
      xl[i] = xi;
      ph[i] = nx;
   endtask

   task automatic cmp_inst(input int i, input string nm, input logic ile, input logic vig,
                           input logic [7:0] xlg, input logic alu, input logic csn,
                           input logic [7:0] rag, input logic [8:0] rdg, input logic rvg,
                           input logic bsy, input logic dn, input logic er);
      phase_t p;
      p = ph[i];
      check_eq({nm, ".input_load_en"}, ile, p == P_LOAD);
      check_eq({nm, ".valid_input"},   vig, vi[i]);
      check_eq({nm, ".X_load"},        xlg, xl[i]);
      check_eq({nm, ".ALU_en"},        alu, p == P_COMPUTE);
      check_eq({nm, ".cs_n"},          csn, p != P_READ);
      check_eq({nm, ".rd_addr"},       rag, ra[i]);
      check_eq({nm, ".result_data"},   rdg, rdat[i]);
      check_eq({nm, ".result_valid"},  rvg, rv[i]);
      check_eq({nm, ".busy"},          bsy, p == P_LOAD || p == P_COMPUTE || p == P_READ || p == P_FIN);
      check_eq({nm, ".done"},          dn,  p == P_FIN);
      check_eq({nm, ".error"},         er,  p == P_ERR);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0, NR_A, TO_A);
      model_step(1, NR_B, TO_B);
      cyc++;
      #1;
      cmp_inst(0, "a", bus_a.input_load_en, bus_a.valid_input, bus_a.X_load, bus_a.ALU_en,
               bus_a.cs_n, bus_a.rd_addr, bus_a.result_data, bus_a.result_valid,
               bus_a.busy, bus_a.done, bus_a.error);
      cmp_inst(1, "b", bus_b.input_load_en, bus_b.valid_input, bus_b.X_load, bus_b.ALU_en,
               bus_b.cs_n, bus_b.rd_addr, bus_b.result_data, bus_b.result_valid,
               bus_b.busy, bus_b.done, bus_b.error);
      if (bus_a.result_valid === 1'b1) rv_cnt_a++;
      if (bus_a.done === 1'b1) done_cnt_a++;
   endtask

   task automatic quiet();
      rst = 1'b0; st = 1'b0; xv = 1'b0; xd = 1'b0; ad = 1'b0; ry = 1'b0;
      xi = 8'd0; rd = 9'd0;
   endtask

   initial begin
      logic [7:0] samples [4];
      logic [8:0] w;
      int d0;
      samples[0] = 8'h11; samples[1] = 8'h22; samples[2] = 8'h33; samples[3] = 8'h44;

      // reset
      rst = 1'b1; tick();
      check_eq("rst_cs_n", bus_a.cs_n, 1'b1);
      check_eq("rst_busy", bus_a.busy, 1'b0);
      check_eq("rst_rd_addr", bus_a.rd_addr, 8'd0);
      quiet();

      // nominal job on the default build
      st = 1'b1; tick(); st = 1'b0;
      for (int k = 0; k < 4; k++) begin
         xv = 1'b1; xi = samples[k]; tick();
         check_eq("nom_X_load", bus_a.X_load, samples[k]);
         check_eq("nom_valid_input", bus_a.valid_input, 1'b1);
      end
      xv = 1'b0; xi = 8'd0;
      xd = 1'b1; tick(); xd = 1'b0;
      check_eq("nom_leave_load_valid", bus_a.valid_input, 1'b0);
      check_eq("nom_ALU_en", bus_a.ALU_en, 1'b1);
      repeat (20) tick();
      ad = 1'b1; tick(); ad = 1'b0;
      check_eq("nom_read_ALU_en", bus_a.ALU_en, 1'b0);
      check_eq("nom_read_cs_n", bus_a.cs_n, 1'b0);
      rv_cnt_a = 0; done_cnt_a = 0;
      for (int k = 0; k < NR_A; k++) begin
         check_eq("nom_rd_addr", bus_a.rd_addr, k);
         w = 9'($urandom_range(511, 0));
         ry = 1'b1; rd = w; tick(); ry = 1'b0;
         check_eq("nom_result_data", bus_a.result_data, w);
         check_eq("nom_result_valid", bus_a.result_valid, 1'b1);
         if (k < NR_A - 1) tick();
      end
      check_eq("nom_done", bus_a.done, 1'b1);
      repeat (3) tick();
      check_eq("nom_rv_count", rv_cnt_a, NR_A);
      check_eq("nom_done_count", done_cnt_a, 1);
      check_eq("nom_idle_busy", bus_a.busy, 1'b0);

      // timeout in COMPUTE
      st = 1'b1; tick(); st = 1'b0;
      xd = 1'b1; tick(); xd = 1'b0;
      repeat (TO_A - 1) tick();
      check_eq("tmo_not_yet", bus_a.error, 1'b0);
      tick();
      check_eq("tmo_error", bus_a.error, 1'b1);
      check_eq("tmo_ALU_en", bus_a.ALU_en, 1'b0);
      check_eq("tmo_cs_n", bus_a.cs_n, 1'b1);
      st = 1'b1; tick(); st = 1'b0;
      check_eq("tmo_clear_error", bus_a.error, 1'b0);
      check_eq("tmo_restart_load", bus_a.input_load_en, 1'b1);

      // ALU_done on the expiry cycle
      xd = 1'b1; tick(); xd = 1'b0;
      repeat (TO_A - 1) tick();
      ad = 1'b1; tick(); ad = 1'b0;
      check_eq("race_cs_n", bus_a.cs_n, 1'b0);
      check_eq("race_error", bus_a.error, 1'b0);

      // reset in the middle of READ
      for (int k = 0; k < 7; k++) begin
         ry = 1'b1; rd = 9'($urandom_range(511, 0)); tick(); ry = 1'b0; tick();
      end
      check_eq("mid_rd_addr7", bus_a.rd_addr, 8'd7);
      d0 = done_cnt_a;
      rst = 1'b1; tick(); rst = 1'b0;
      check_eq("mid_rst_cs_n", bus_a.cs_n, 1'b1);
      check_eq("mid_rst_rd_addr", bus_a.rd_addr, 8'd0);
      check_eq("mid_rst_busy", bus_a.busy, 1'b0);
      repeat (3) tick();
      check_eq("mid_rst_no_done", done_cnt_a, d0);

      // spurious inputs
      ry = 1'b1; ad = 1'b1; tick(); ry = 1'b0; ad = 1'b0;
      check_eq("spur_idle_busy", bus_a.busy, 1'b0);
      check_eq("spur_idle_rv", bus_a.result_valid, 1'b0);
      st = 1'b1; tick(); st = 1'b0;
      xd = 1'b1; tick(); xd = 1'b0;
      st = 1'b1; ry = 1'b1; tick(); st = 1'b0; ry = 1'b0;
      check_eq("spur_start_ALU_en", bus_a.ALU_en, 1'b1);
      check_eq("spur_start_load", bus_a.input_load_en, 1'b0);
      check_eq("spur_ry_rv", bus_a.result_valid, 1'b0);

      // single-word job on the NUM_READ=1 build
      rst = 1'b1; tick(); rst = 1'b0;
      st = 1'b1; tick(); st = 1'b0;
      xd = 1'b1; tick(); xd = 1'b0;
      ad = 1'b1; tick(); ad = 1'b0;
      ry = 1'b1; rd = 9'h1A5; tick(); ry = 1'b0;
      check_eq("nr1_result_valid", bus_b.result_valid, 1'b1);
      check_eq("nr1_result_data", bus_b.result_data, 9'h1A5);
      check_eq("nr1_done", bus_b.done, 1'b1);
      check_eq("nr1_rd_addr", bus_b.rd_addr, 8'd0);
      tick();
      check_eq("nr1_idle", bus_b.busy, 1'b0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(99, 0) == 0);
         st  = ($urandom_range(9, 0) == 0);
         xv  = $urandom_range(1, 0) == 1;
         xi  = 8'($urandom_range(255, 0));
         xd  = ($urandom_range(9, 0) == 0);
         ad  = ($urandom_range(9, 0) == 0);
         ry  = ($urandom_range(9, 0) < 3);
         rd  = 9'($urandom_range(511, 0));
         tick();
      end
      quiet();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule

// File: doc/logic_seq_ctrl.md
LOGIC_SEQ_CTRL -- requirements
Module: logic_seq_ctrl

Interface
REQ-001 Parameter NUM_READ, default 16: number of result words read back from SRAM per job, range 1..256.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles allowed in LOAD, COMPUTE or per READ word before error.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  host job request, sampled only in IDLE or ERR.
REQ-006 x_in_valid  in  1  host input-sample strobe.
REQ-007 x_in  in  8  host input sample.
REQ-008 xload_done  in  1  X buffer full.
REQ-009 ALU_done  in  1  ALU finished and results written to SRAM.
REQ-010 ry  in  1  SRAM read data ready.
REQ-011 read_data  in  9  SRAM read word.
REQ-012 input_load_en  out  1  enables X buffer loading.
REQ-013 valid_input  out  1  registered copy of x_in_valid, gated by LOAD.
REQ-014 X_load  out  8  registered copy of x_in.
REQ-015 ALU_en  out  1  enables ALU sequencing.
REQ-016 cs_n  out  1  SRAM chip select, active-low.
REQ-017 rd_addr  out  8  read-back word index.
REQ-018 result_data  out  9  captured read word; result_valid  out  1  one-cycle strobe.
REQ-019 busy  out  1  high in any state except IDLE/ERR; done  out  1  one-cycle job-complete pulse; error  out  1  sticky timeout flag.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, COMPUTE, READ, FIN, ERR.
REQ-021 IDLE: start=1 -> LOAD next cycle; wdog and rd_addr cleared.
REQ-022 LOAD: input_load_en=1; valid_input/X_load = x_in_valid/x_in delayed one cycle; xload_done=1 -> COMPUTE.
REQ-023 valid_input SHALL be 0 in every state except LOAD, including the first cycle after leaving LOAD.
REQ-024 COMPUTE: ALU_en=1; ALU_done=1 -> READ; ALU_en deasserts the cycle READ is entered.
REQ-025 READ: cs_n=0; on ry=1, result_data<=read_data, result_valid=1 for one cycle, rd_addr increments, wdog clears.
REQ-026 READ exits to FIN on the ry capturing word NUM_READ-1; rd_addr wraps to 0 on that capture.
REQ-027 FIN: done=1 for exactly one cycle, cs_n=1, then IDLE.
REQ-028 Watchdog: counter cleared on every state entry and each READ capture; reaching TIMEOUT in LOAD/COMPUTE/READ -> ERR, error=1.
REQ-029 Simultaneous completion event (xload_done/ALU_done/ry) and timeout in one cycle: completion wins, no error.
REQ-030 ERR: all enables deasserted, cs_n=1; error held; start=1 clears error and -> LOAD.
REQ-031 start while busy SHALL be ignored, no queuing.
REQ-032 ry outside READ, ALU_done outside COMPUTE, xload_done outside LOAD SHALL be ignored.

Reset
REQ-033 rst=1 at any clock edge, including mid-job, SHALL force IDLE next cycle: cs_n=1, all other outputs 0, rd_addr=0, wdog=0, result_data=0.
REQ-034 rst SHALL take priority over every other input.

Structure
REQ-035 State encoding enum and default NUM_READ/TIMEOUT constants SHALL reside in the shared logic package.
REQ-036 Watchdog counter SHALL be one sub-module, seq_wdog (clear, enable, expired), width derived from TIMEOUT.

Verification
REQ-037 Nominal: start, 4 x_in strobes (0x11,0x22,0x33,0x44), xload_done, ALU_done after 20 cycles, 16 ry pulses -> X_load/valid_input mirror with 1-cycle delay, 16 result_valid strobes with rd_addr 0..15, one done pulse, back to IDLE.
REQ-038 Timeout: withhold ALU_done -> ERR exactly TIMEOUT cycles after COMPUTE entry, error=1, ALU_en=0; start -> error=0, LOAD.
REQ-039 Race: ALU_done asserted on the cycle wdog reaches TIMEOUT -> READ entered, error stays 0.
REQ-040 Mid-job reset: rst during READ at rd_addr=7 -> next cycle IDLE, cs_n=1, rd_addr=0, no done pulse.
REQ-041 Spurious inputs: ry and ALU_done pulsed in IDLE; start pulsed in COMPUTE -> no state change, no result_valid.
REQ-042 NUM_READ=1 build: single ry in READ -> one result_valid, FIN next cycle, rd_addr=0.
